// File: rtl/bit_serial_alu_seq.sv
// Bit-serial sequencer around an external 1-bit ALU slice: feeds one bit pair per clock LSB first,
// chains carry through a flop, reassembles the result. Optional macro SLT_OVF_FIX_EN corrects SLT on overflow.
module bit_serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ovf,
  output logic             err,
  output logic             alu_ainvert,
  output logic             alu_binvert,
  output logic             alu_cin,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_less,
  output logic [1:0]       alu_s,
  input  logic             alu_result,
  input  logic             alu_cout
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {IDLE, RUN, SLT_FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             msb_q, msb_d;

  logic       dec_ainv, dec_binv, dec_arith, dec_slt;
  logic [1:0] dec_sel;
  logic       op_legal;
  logic       slt_set;

  always_comb begin
    op_legal = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR);
  end

  // Slice control for the latched op; only legal ops ever reach RUN.
  always_comb begin
    dec_ainv  = 1'b0;
    dec_binv  = 1'b0;
    dec_sel   = 2'b00;
    dec_arith = 1'b0;
    dec_slt   = 1'b0;
    case (op_q)
      OP_OR:  dec_sel = 2'b01;
      OP_ADD: begin dec_sel = 2'b10; dec_arith = 1'b1; end
      OP_SUB: begin dec_sel = 2'b10; dec_binv = 1'b1; dec_arith = 1'b1; end
      OP_SLT: begin dec_sel = 2'b10; dec_binv = 1'b1; dec_arith = 1'b1; dec_slt = 1'b1; end
      OP_NOR: begin dec_ainv = 1'b1; dec_binv = 1'b1; end
      default: ;
    endcase
  end

`ifdef SLT_OVF_FIX_EN
  assign slt_set = msb_q ^ ovf_q;
`else
  assign slt_set = msb_q;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    op_d        = op_q;
    y_d         = y_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    msb_d       = msb_q;
    alu_ainvert = 1'b0;
    alu_binvert = 1'b0;
    alu_cin     = 1'b0;
    alu_a       = 1'b0;
    alu_b       = 1'b0;
    alu_less    = 1'b0;
    alu_s       = 2'b00;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = opa;
          opb_d   = opb;
          op_d    = op;
          idx_d   = '0;
          carry_d = 1'b0;
          y_d     = '0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          msb_d   = 1'b0;
          err_d   = !op_legal;
          state_d = op_legal ? RUN : DONE;
        end
      end
      RUN: begin
        alu_ainvert = dec_ainv;
        alu_binvert = dec_binv;
        alu_s       = dec_sel;
        alu_a       = opa_q[idx_q];
        alu_b       = opb_q[idx_q];
        alu_cin     = (idx_q == '0) ? dec_binv : carry_q;
        carry_d     = alu_cout;
        if (!dec_slt) y_d[idx_q] = alu_result;
        if (idx_q == LAST) begin
          if (dec_arith) ovf_d = alu_cin ^ alu_cout;
          msb_d   = alu_result;
          state_d = dec_slt ? SLT_FIX : DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SLT_FIX: begin
        y_d     = {{(WIDTH-1){1'b0}}, slt_set};
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // zero is registered on entry to DONE so it is valid on the done cycle and holds after.
    if (state_d == DONE && state_q != DONE) zero_d = (y_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      msb_q   <= msb_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign y    = y_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
  assign err  = err_q;
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Bench for bit_serial_alu_seq: behavioural 1-bit slice wired to the DUT, arithmetic reference model,
// directed vectors, random ops, busy/back-to-back/reset-in-flight scenarios.
module tb_bit_serial_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'b0;
  logic [W-1:0] opa = '0, opb = '0;
  logic         busy, done, zero, ovf, err;
  logic [W-1:0] y;
  logic         alu_ainvert, alu_binvert, alu_cin, alu_a, alu_b, alu_less;
  logic [1:0]   alu_s;
  logic         alu_result, alu_cout;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .y(y), .zero(zero), .ovf(ovf), .err(err),
    .alu_ainvert(alu_ainvert), .alu_binvert(alu_binvert), .alu_cin(alu_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_less(alu_less), .alu_s(alu_s),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  // Classic 1-bit MIPS ALU slice.
  logic sa, sb;
  assign sa = alu_a ^ alu_ainvert;
  assign sb = alu_b ^ alu_binvert;
  assign alu_cout = (sa & sb) | (alu_cin & (sa ^ sb));
  always_comb begin
    alu_result = 1'b0;
    case (alu_s)
      2'b00: alu_result = sa & sb;
      2'b01: alu_result = sa | sb;
      2'b10: alu_result = sa ^ sb ^ alu_cin;
      default: alu_result = alu_less;
    endcase
  end

  // Reference: whole-word arithmetic; latency counted as cycles after the accepting edge.
  task automatic ref_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] ey, output logic eovf, output logic eerr, output int elat);
    logic [W-1:0] d;
    ey = '0; eovf = 1'b0; eerr = 1'b0; elat = W + 1;
    case (o)
      4'b0000: ey = a & b;
      4'b0001: ey = a | b;
      4'b1100: ey = ~(a | b);
      4'b0010: begin ey = a + b; eovf = (a[W-1] == b[W-1]) && (ey[W-1] != a[W-1]); end
      4'b0110: begin ey = a - b; eovf = (a[W-1] != b[W-1]) && (ey[W-1] != a[W-1]); end
      4'b0111: begin
        d = a - b;
        eovf = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
`ifdef SLT_OVF_FIX_EN
        ey[0] = ($signed(a) < $signed(b));
`else
        ey[0] = d[W-1];
`endif
        elat = W + 2;
      end
      default: begin eerr = 1'b1; elat = 1; end
    endcase
  endtask

  // Drives one op and captures outputs on the done cycle plus whether they hold one cycle later.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] ry, output logic rz, output logic rovf, output logic rerr,
                        output int lat, output logic pulse_ok, output logic hold_ok);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; op = 4'($urandom); opa = W'($urandom); opb = W'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    ry = y; rz = zero; rovf = ovf; rerr = err;
    @(posedge clk); #1;
    pulse_ok = !done && !busy;
    hold_ok = (y === ry) && (zero === rz) && (ovf === rovf) && (err === rerr);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({busy, done, y, zero, ovf, err} !== '0) $display("FAIL reset_outputs got=%h want=0", {busy, done, y, zero, ovf, err});
    else n_pass++;
    n_chk++;
    if ({alu_ainvert, alu_binvert, alu_cin, alu_a, alu_b, alu_less, alu_s} !== 8'h00)
      $display("FAIL reset_slice got=%h want=00", {alu_ainvert, alu_binvert, alu_cin, alu_a, alu_b, alu_less, alu_s});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic check_op(input string tag, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ry, ey; logic rz, rovf, rerr, eovf, eerr, pok, hok; int lat, elat;
    ref_op(o, a, b, ey, eovf, eerr, elat);
    run_op(o, a, b, ry, rz, rovf, rerr, lat, pok, hok);
    n_chk++; if (ry !== ey) $display("FAIL %s_y op=%b a=%h b=%h got=%h want=%h", tag, o, a, b, ry, ey); else n_pass++;
    n_chk++; if (rz !== (ey == '0)) $display("FAIL %s_zero op=%b got=%b want=%b", tag, o, rz, (ey == '0)); else n_pass++;
    n_chk++; if (rovf !== eovf) $display("FAIL %s_ovf op=%b a=%h b=%h got=%b want=%b", tag, o, a, b, rovf, eovf); else n_pass++;
    n_chk++; if (rerr !== eerr) $display("FAIL %s_err op=%b got=%b want=%b", tag, o, rerr, eerr); else n_pass++;
    n_chk++; if (lat !== elat) $display("FAIL %s_latency op=%b got=%0d want=%0d", tag, o, lat, elat); else n_pass++;
    n_chk++; if (pok !== 1'b1) $display("FAIL %s_done_pulse op=%b got=%b want=1", tag, o, pok); else n_pass++;
    n_chk++; if (hok !== 1'b1) $display("FAIL %s_hold op=%b got=%b want=1", tag, o, hok); else n_pass++;
  endtask

  task automatic test_directed;
    check_op("add_ovf",  4'b0010, 8'h7F, 8'h01);
    check_op("sub_zero", 4'b0110, 8'h05, 8'h05);
    check_op("add_wrap", 4'b0010, 8'hFF, 8'h01);
    check_op("slt_ovf",  4'b0111, 8'h80, 8'h01);
    check_op("slt_neg",  4'b0111, 8'hFE, 8'h03);
    check_op("nor",      4'b1100, 8'hF0, 8'h0C);
    check_op("and",      4'b0000, 8'hF0, 8'h3C);
    check_op("or",       4'b0001, 8'hF0, 8'h3C);
    check_op("illegal",  4'b1111, 8'hAA, 8'h55);
  endtask

  task automatic test_random;
    logic [3:0] ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011};
    logic [3:0] o;
    for (int i = 0; i < 120; i++) begin
      o = ops[$urandom_range(0, 6)];
      if (o == 4'b0011) o = (i % 2 == 0) ? 4'b1111 : 4'b1000;
      check_op("rand", o, W'($urandom), W'($urandom));
    end
  endtask

  task automatic test_busy_start;
    int lat;
    @(negedge clk);
    start = 1'b1; op = 4'b0010; opa = 8'h12; opb = 8'h34;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 4'b0001; opa = 8'hFF; opb = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    n_chk++; if (y !== 8'h46) $display("FAIL busy_start_y got=%h want=46", y); else n_pass++;
    n_chk++; if (lat !== W + 1) $display("FAIL busy_start_latency got=%0d want=%0d", lat, W + 1); else n_pass++;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL busy_start_not_queued got=%b want=0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int t, t1, t2;
    @(negedge clk);
    start = 1'b1; op = 4'b0010; opa = 8'h21; opb = 8'h10;
    t = 0; t1 = -1; t2 = -1;
    while (t < 60 && t2 < 0) begin
      @(posedge clk); #1; t++;
      if (done) begin if (t1 < 0) t1 = t; else t2 = t; end
    end
    @(negedge clk); start = 1'b0;
    n_chk++; if (t2 - t1 !== W + 2) $display("FAIL back_to_back_gap got=%0d want=%0d", t2 - t1, W + 2); else n_pass++;
    n_chk++; if (y !== 8'h31) $display("FAIL back_to_back_y got=%h want=31", y); else n_pass++;
    repeat (W + 3) @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    logic seen;
    @(negedge clk);
    start = 1'b1; op = 4'b0010; opa = 8'h7F; opb = 8'h01;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({busy, done, y, zero, ovf, err} !== '0) $display("FAIL midrun_reset_outputs got=%h want=0", {busy, done, y, zero, ovf, err});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (W + 4) begin @(negedge clk); seen |= done | busy; end
    n_chk++; if (seen !== 1'b0) $display("FAIL midrun_no_done got=%b want=0", seen); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_busy_start;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
